// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: synchronizes the raw bus, deframes 11-bit frames,
// folds E0/F0 prefixes into flags and queues {break, extended, scancode} in a FIFO.
module ps2_kb_rx #(
  parameter int TIMEOUT = 50000,
  parameter int DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       ps2kb_rd,
  output logic [9:0] ps2kb_key,
  output logic       ps2kb_empty,
  output logic       ps2kb_overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Odd parity over data plus parity bit: a good frame XORs to 1.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic [2:0]    r_pclk_sync;
  logic [1:0]    r_pdat_sync;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_ext;
  logic          r_brk;
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_rd_prev;
  logic [9:0]    r_key;
  logic          r_empty;
  logic          r_ovf;
  logic          r_ferr;

  logic          w_fall;
  logic          w_bit;
  logic          w_tmo;
  logic          w_good;
  logic          w_bad;
  logic          w_push_req;
  logic [9:0]    w_push_data;
  logic          w_pop_req;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [9:0]    w_head_nxt;

  // Synchronizers idle high so reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pclk_sync <= 3'b111;
      r_pdat_sync <= 2'b11;
    end else begin
      r_pclk_sync <= {r_pclk_sync[1:0], ps2_clk};
      r_pdat_sync <= {r_pdat_sync[0], ps2_data};
    end
  end

  assign w_fall = r_pclk_sync[2] & ~r_pclk_sync[1];
  assign w_bit  = r_pdat_sync[1];
  assign w_tmo  = (r_state != IDLE) && !w_fall && (r_tmo_cnt == TMO_LAST);

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and frame verdict; a real edge always wins over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    if (w_tmo) begin
      w_state_nxt = IDLE;
    end else if (w_fall) begin
      case (r_state)
        IDLE: begin
          if (!w_bit) begin
            w_state_nxt = DATA;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        DATA: begin
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = PARITY;
          end else begin
            w_state_nxt = DATA;
          end
        end
        PARITY: w_state_nxt = STOP;
        STOP: begin
          w_state_nxt = IDLE;
          if (w_bit && odd_parity_ok(r_shift, r_parity)) begin
            w_good = 1'b1;
          end else begin
            w_bad = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Bit shifter, parity capture and inactivity counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
      r_parity  <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      if ((r_state == IDLE) || w_fall || w_tmo) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end
      if (w_tmo) begin
        r_bit_cnt <= 3'd0;
        r_shift   <= 8'd0;
      end else if (w_fall) begin
        case (r_state)
          IDLE: begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
          end
          DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          PARITY:  r_parity <= w_bit;
          default: r_parity <= r_parity;
        endcase
      end else begin
        r_bit_cnt <= r_bit_cnt;
      end
    end
  end

  assign w_push_req  = w_good && (r_shift != 8'hE0) && (r_shift != 8'hF0);
  assign w_push_data = {r_brk, r_ext, r_shift};

  // Prefix flags; any non-prefix byte consumes them whether or not it fits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_good) begin
      if (r_shift == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_shift == 8'hF0) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end else begin
      r_ext <= r_ext;
    end
  end

  // Pop on a push into an empty FIFO passes the key straight through.
  assign w_pop_req    = ps2kb_rd & ~r_rd_prev;
  assign w_pop        = w_pop_req && ((r_count != '0) || w_push_req);
  assign w_push       = w_push_req && ((r_count != FULL_CNT) || w_pop);
  assign w_drop       = w_push_req && (r_count == FULL_CNT) && !w_pop;
  assign w_rd_ptr_nxt = w_pop  ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
  assign w_wr_ptr_nxt = w_push ? (r_wr_ptr + AW'(1)) : r_wr_ptr;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_cnt_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_count + CW'(1);
      2'b01:   w_cnt_nxt = r_count - CW'(1);
      default: w_cnt_nxt = r_count;
    endcase
  end

  // Head entry as it will look after this cycle's update.
  always_comb begin
    w_head_nxt = 10'h000;
    if (w_cnt_nxt == '0) begin
      w_head_nxt = 10'h000;
    end else if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_nxt = w_push_data;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Storage array; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // FIFO pointers, count, read-strobe history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_rd_prev <= 1'b0;
      r_key     <= 10'h000;
      r_empty   <= 1'b1;
      r_ovf     <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_count   <= w_cnt_nxt;
      r_rd_prev <= ps2kb_rd;
      r_key     <= w_head_nxt;
      r_empty   <= (w_cnt_nxt == '0);
      r_ovf     <= r_ovf | w_drop;
      r_ferr    <= w_bad | w_tmo;
    end
  end

  assign ps2kb_key      = r_key;
  assign ps2kb_empty    = r_empty;
  assign ps2kb_overflow = r_ovf;
  assign frame_err      = r_ferr;

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Randomized bench for ps2_kb_rx: a queue-based key model is compared every
// settled cycle, with literal expectations pinning the model on known sequences.
module tb_ps2_kb_rx;
  localparam int TMO = 300;
  localparam int DEP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ps2kb_rd = 1'b0;
  logic [9:0] ps2kb_key;
  logic       ps2kb_empty;
  logic       ps2kb_overflow;
  logic       frame_err;

  ps2_kb_rx #(.TIMEOUT(TMO), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2kb_rd(ps2kb_rd), .ps2kb_key(ps2kb_key), .ps2kb_empty(ps2kb_empty),
    .ps2kb_overflow(ps2kb_overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [9:0] mdl_q[$];
  logic       mdl_ext = 1'b0;
  logic       mdl_brk = 1'b0;
  logic       mdl_ovf = 1'b0;
  int         exp_err = 0;
  int         err_seen = 0;
  logic       prev_err = 1'b0;
  bit         chk_en = 1'b0;
  int         half = 6;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: a frame is judged by stop/odd parity, then decoded into the key queue.
  task automatic model_frame(input logic [7:0] b, input logic par, input logic stp);
    if (!(stp && ((^b ^ par) == 1'b1))) begin
      exp_err++;
    end else if (b == 8'hE0) begin
      mdl_ext = 1'b1;
    end else if (b == 8'hF0) begin
      mdl_brk = 1'b1;
    end else begin
      if (mdl_q.size() < DEP) mdl_q.push_back({mdl_brk, mdl_ext, b});
      else mdl_ovf = 1'b1;
      mdl_ext = 1'b0;
      mdl_brk = 1'b0;
    end
  endtask

  task automatic model_pop();
    if (mdl_q.size() != 0) void'(mdl_q.pop_front());
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_clk(half);
    ps2_clk = 1'b0;
    wait_clk(half);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) ps2_bit(bits[i]);
  endtask

  // Leaves the bench right after the stop-bit falling edge, checking disabled.
  task automatic frame_to_stop_fall(input logic [7:0] b, input logic par, input logic stp);
    send_bits({stp, par, b, 1'b0}, 10);
    ps2_data = stp;
    wait_clk(half);
    chk_en = 1'b0;
    ps2_clk = 1'b0;
  endtask

  task automatic frame_finish();
    wait_clk(half);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_clk(half);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    frame_to_stop_fall(b, par, stp);
    wait_clk(4);
    model_frame(b, par, stp);
    chk_en = 1'b1;
    frame_finish();
  endtask

  task automatic send_key(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1);
  endtask

  task automatic do_read(input int hold);
    chk_en = 1'b0;
    ps2kb_rd = 1'b1;
    wait_clk(1);
    model_pop();
    chk_en = 1'b1;
    wait_clk(hold - 1);
    ps2kb_rd = 1'b0;
    wait_clk(1);
  endtask

  task automatic reset_dut();
    chk_en = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    ps2kb_rd = 1'b0;
    rst = 1'b1;
    wait_clk(3);
    check("rst_key", 32'(ps2kb_key), 32'h0);
    check("rst_empty", 32'(ps2kb_empty), 32'h1);
    check("rst_ovf", 32'(ps2kb_overflow), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    rst = 1'b0;
    mdl_q.delete();
    mdl_ext = 1'b0;
    mdl_brk = 1'b0;
    mdl_ovf = 1'b0;
    wait_clk(2);
    chk_en = 1'b1;
  endtask

  // Start bit plus n data bits, then silence long enough to hit the timeout.
  task automatic partial_timeout(input int n);
    send_bits({3'b111, 8'($urandom), 1'b0}, n + 1);
    chk_en = 1'b0;
    wait_clk(TMO + 5);
    exp_err++;
    chk_en = 1'b1;
  endtask

  // Push lands on the same clk edge as a fresh read-strobe rising edge.
  task automatic push_with_pop(input logic [7:0] b, input bit was_empty);
    frame_to_stop_fall(b, ~^b, 1'b1);
    wait_clk(2);
    ps2kb_rd = 1'b1;
    wait_clk(2);
    if (was_empty) begin
      model_frame(b, ~^b, 1'b1);
      model_pop();
    end else begin
      model_pop();
      model_frame(b, ~^b, 1'b1);
    end
    chk_en = 1'b1;
    frame_finish();
    ps2kb_rd = 1'b0;
    wait_clk(1);
  endtask

  // Per-cycle comparison against the model whenever the outputs are settled.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("key", 32'(ps2kb_key), (mdl_q.size() != 0) ? 32'(mdl_q[0]) : 32'h0);
      check("empty", 32'(ps2kb_empty), 32'(mdl_q.size() == 0));
      check("ovf", 32'(ps2kb_overflow), 32'(mdl_ovf));
      check("err_count", 32'(err_seen), 32'(exp_err));
    end
  end

  // frame_err pulses are counted and must never last two cycles.
  always @(negedge clk) begin
    if (frame_err) begin
      err_seen++;
      if (prev_err) check("err_width", 32'(prev_err), 32'h0);
    end
    prev_err = frame_err;
  end

  initial begin
    int e0;
    reset_dut();

    // Single key with exact latency after the stop edge.
    frame_to_stop_fall(8'h1C, 1'b0, 1'b1);
    wait_clk(2);
    check("lat_early_empty", 32'(ps2kb_empty), 32'h1);
    wait_clk(1);
    check("lat_key", 32'(ps2kb_key), 32'h01C);
    check("lat_empty", 32'(ps2kb_empty), 32'h0);
    model_frame(8'h1C, 1'b0, 1'b1);
    check("model_1c", 32'(mdl_q[0]), 32'h01C);
    chk_en = 1'b1;
    frame_finish();
    do_read(2);

    // Extended break code.
    send_key(8'hE0);
    send_key(8'hF0);
    send_key(8'h75);
    check("ext_brk_key", 32'(ps2kb_key), 32'h375);
    check("ext_brk_depth", 32'(mdl_q.size()), 32'd1);
    do_read(3);
    check("after_read_key", 32'(ps2kb_key), 32'h000);
    check("after_read_empty", 32'(ps2kb_empty), 32'h1);

    // Parity and stop-bit errors.
    e0 = err_seen;
    send_frame(8'h1C, 1'b1, 1'b1);
    check("parity_err", 32'(err_seen - e0), 32'd1);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("stop_err", 32'(err_seen - e0), 32'd2);
    check("err_empty", 32'(ps2kb_empty), 32'h1);

    // Overflow on the fifth key.
    reset_dut();
    send_key(8'h16); send_key(8'h1E); send_key(8'h26); send_key(8'h25); send_key(8'h2E);
    check("ovf_set", 32'(ps2kb_overflow), 32'h1);
    check("ovf_head0", 32'(ps2kb_key), 32'h016);
    do_read(1);
    check("ovf_head1", 32'(ps2kb_key), 32'h01E);
    do_read(1);
    check("ovf_head2", 32'(ps2kb_key), 32'h026);
    do_read(1);
    check("ovf_head3", 32'(ps2kb_key), 32'h025);
    do_read(1);
    check("ovf_drained", 32'(ps2kb_empty), 32'h1);

    // Held read strobe pops once; simultaneous push/pop at full and empty.
    reset_dut();
    send_key(8'h1C); send_key(8'h32);
    do_read(10);
    check("hold_one_pop", 32'(ps2kb_key), 32'h032);
    send_key(8'h21); send_key(8'h23); send_key(8'h24);
    push_with_pop(8'h2B, 1'b0);
    check("full_pp_ovf", 32'(ps2kb_overflow), 32'h0);
    check("full_pp_head", 32'(ps2kb_key), 32'h021);
    for (int i = 0; i < DEP; i++) do_read(1);
    check("full_pp_drained", 32'(ps2kb_empty), 32'h1);
    push_with_pop(8'h34, 1'b1);
    check("empty_pp_empty", 32'(ps2kb_empty), 32'h1);

    // Timeout on a partial frame, then recovery.
    e0 = err_seen;
    partial_timeout(4);
    check("tmo_err", 32'(err_seen - e0), 32'd1);
    send_key(8'h1C);
    check("tmo_recover", 32'(ps2kb_key), 32'h01C);

    // Randomized traffic.
    reset_dut();
    for (int it = 0; it < 80; it++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(99));
      half = int'($urandom_range(10, 4));
      if (r < 65) begin
        b = 8'($urandom);
        if ($urandom_range(7) == 0) b = 8'hE0;
        else if ($urandom_range(9) == 0) b = 8'hF0;
        send_frame(b, ($urandom_range(9) == 0) ? ^b : ~^b, ($urandom_range(9) != 0));
      end else if (r < 88) begin
        do_read(int'($urandom_range(6, 1)));
      end else if (r < 94) begin
        partial_timeout(int'($urandom_range(7)));
      end else begin
        send_bits({3'b111, 8'($urandom), 1'b0}, int'($urandom_range(9, 1)));
        reset_dut();
      end
    end
    wait_clk(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_kb_rx.md
PS2_KB_RX -- requirements
Module: ps2_kb_rx

Interface
REQ-001 Parameter TIMEOUT, default 50000, is the number of clk cycles without a ps2_clk falling edge after which a partial frame is abandoned.
REQ-002 Parameter DEPTH, default 4, is the key FIFO depth; the value SHALL be a power of 2 and at least 2.
REQ-003 Port clk, input, 1 bit: system clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port ps2_clk, input, 1 bit: raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 Port ps2_data, input, 1 bit: raw PS/2 data, asynchronous to clk.
REQ-007 Port ps2kb_rd, input, 1 bit: bus read strobe; the bus MAY hold it high for several cycles.
REQ-008 Port ps2kb_key, output, 10 bits: {break, extended, scancode[7:0]} at the FIFO head, or 10'h000 when the FIFO is empty.
REQ-009 Port ps2kb_empty, output, 1 bit: high when the FIFO holds no entry.
REQ-010 Port ps2kb_overflow, output, 1 bit: sticky flag, set when a key was dropped because the FIFO was full.
REQ-011 Port frame_err, output, 1 bit: one-cycle pulse on a parity, stop-bit or timeout failure.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is a third-stage 1 followed by a second-stage 0.
REQ-013 The frame FSM SHALL have the states IDLE, DATA, PARITY and STOP, and SHALL act only on ps2_clk falling edges, except for the timeout in REQ-017.
REQ-014 In IDLE, an edge with data=0 (start bit) SHALL move the FSM to DATA; an edge with data=1 SHALL leave it in IDLE.
REQ-015 In DATA, the FSM SHALL sample 8 bits LSB first on 8 edges, then move to PARITY; it SHALL sample the parity bit on one edge, then move to STOP.
REQ-016 On the STOP edge, the frame is good when stop=1 and the XOR of the 8 data bits and parity equals 1 (odd parity); a good frame delivers its byte to the decoder, a bad frame pulses frame_err; in both cases the FSM SHALL return to IDLE.
REQ-017 In any state other than IDLE, a cycle counter SHALL reset on each edge; when it reaches TIMEOUT the FSM SHALL go to IDLE, discard the partial byte and pulse frame_err once.
REQ-018 Decoder: byte E0 SHALL set the ext flag, byte F0 SHALL set the brk flag, and neither SHALL push to the FIFO.
REQ-019 Decoder: any other byte SHALL push {brk, ext, byte} into the FIFO and clear both flags in the same cycle.
REQ-020 A pushed entry SHALL be visible on ps2kb_key in the cycle after the STOP edge is detected.
REQ-021 A pop SHALL occur only on the rising edge of ps2kb_rd (registered previous value 0, current 1); holding ps2kb_rd high pops exactly once.
REQ-022 A pop on an empty FIFO SHALL be ignored.
REQ-023 When the FIFO is full, a push with no pop in the same cycle SHALL drop the entry and set ps2kb_overflow; the flag SHALL stay set until rst.
REQ-024 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full or empty; the occupancy count is then unchanged.
REQ-025 The read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0; the occupancy count SHALL be log2(DEPTH)+1 bits.
REQ-026 ps2kb_key and ps2kb_empty SHALL be driven from FIFO state only; neither SHALL depend combinationally on ps2kb_rd.

Reset
REQ-027 While rst=1 at a clk edge, the block SHALL set: FSM to IDLE, bit counter and timeout counter to 0, shift register to 0, ext and brk flags to 0, FIFO pointers and count to 0, and the registered ps2kb_rd to 0.
REQ-028 While rst=1 at a clk edge, the outputs SHALL be ps2kb_key=0, ps2kb_empty=1, ps2kb_overflow=0 and frame_err=0.
REQ-029 The synchronizer flops SHALL reset to 1 (the bus idle level), so that reset release creates no false edge.
REQ-030 Reset asserted mid-frame SHALL abandon the frame without pulsing frame_err.

Verification
REQ-031 Send frame 0x1C with parity=0 and stop=1 -> one cycle after STOP, ps2kb_key=0x01C and ps2kb_empty=0.
REQ-032 Send E0, F0, 75 with no read in between -> exactly one entry, ps2kb_key=0x375; then pulse ps2kb_rd -> ps2kb_key=0x000 and ps2kb_empty=1.
REQ-033 Send 0x1C with parity=1 -> frame_err high for exactly 1 cycle and ps2kb_empty stays 1; send 0x1C with stop=0 -> same response.
REQ-034 Send 5 keys 0x16, 0x1E, 0x26, 0x25, 0x2E with no reads -> ps2kb_overflow=1; four successive pops read 0x016, 0x01E, 0x026, 0x025, then ps2kb_empty=1.
REQ-035 Hold ps2kb_rd high for 10 cycles with 2 entries queued -> exactly one pop, 1 entry remains; push in the same cycle as a pop while full -> count stays at DEPTH.
REQ-036 Send start plus 4 data bits, then idle for TIMEOUT+5 cycles -> one frame_err pulse and FSM in IDLE; a following good 0x1C frame -> ps2kb_key=0x01C.
